cpu_run_controller: RTL

Execution sequencer for the lab CPU on the debug board. Turns debounced one-shot step/run/halt commands into single-cycle CPU clock-enable ticks, paced by a programmable divider. Supports N-cycle bursts, free run, and a single PC breakpoint. Sits between the button front-end (debouncer + one-shot) and the CPU clock enable; its state and counters feed the state display.

---
 rtl/cpu_run_controller_pkg.sv | 18 +
 rtl/cpu_run_controller_tick_divider.sv | 28 ++
 rtl/cpu_run_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_run_controller_pkg.sv
// rtl/cpu_run_controller_pkg.sv - run-state encodings shared with the state display
package cpu_run_controller_pkg;

  localparam int STATE_WIDTH      = 2;
  localparam int TICK_COUNT_WIDTH = 16;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_RUN   = 2'd2,
    S_BREAK = 2'd3
  } run_state_t;

  function automatic logic is_ticking(input run_state_t s);
    return (s == S_STEP) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/cpu_run_controller_tick_divider.sv
// rtl/cpu_run_controller_tick_divider.sv - pacing counter that flags a due point
module tick_divider
  import cpu_run_controller_pkg::*;
#(
  parameter int p_rate_width = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [p_rate_width-1:0] rate_div,
  output logic                    due
);

  logic [p_rate_width-1:0] count;

  // >= rather than == so lowering the divisor mid-count fires immediately
  assign due = enable && (count >= rate_div);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !due) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - step/run/halt sequencer producing paced CPU clock-enable ticks
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int p_address_width = 10,
  parameter int p_count_width   = 8,
  parameter int p_rate_width    = 24
) (
  input  logic                        i_w_clk,
  input  logic                        i_w_reset,
  input  logic                        i_w_step,
  input  logic                        i_w_run,
  input  logic                        i_w_halt,
  input  logic [p_count_width-1:0]    i_w_step_count,
  input  logic [p_rate_width-1:0]     i_w_rate_div,
  input  logic                        i_w_bp_en,
  input  logic [p_address_width-1:0]  i_w_bp_addr,
  input  logic [p_address_width-1:0]  i_w_cpu_pc,
  output logic                        o_w_cpu_tick,
  output logic [STATE_WIDTH-1:0]      o_w_state,
  output logic                        o_w_bp_hit,
  output logic [TICK_COUNT_WIDTH-1:0] o_w_tick_count
);

  localparam logic [p_count_width-1:0] count_one = {{(p_count_width-1){1'b0}}, 1'b1};

  run_state_t                  state;
  logic [p_count_width-1:0]    remaining;
  logic                        skip;
  logic [TICK_COUNT_WIDTH-1:0] tick_count;
  logic                        due;
  logic                        bp_block;
  logic                        tick;
  logic                        start;
  logic [p_count_width-1:0]    burst_len;

  assign start     = !i_w_halt && !is_ticking(state) && (i_w_run || i_w_step);
  assign bp_block  = due && i_w_bp_en && (i_w_cpu_pc == i_w_bp_addr) && !skip;
  assign tick      = due && !bp_block && !i_w_halt && !i_w_reset;
  assign burst_len = (i_w_step_count == '0) ? count_one : i_w_step_count;

  tick_divider #(
    .p_rate_width(p_rate_width)
  ) u_divider (
    .clk     (i_w_clk),
    .reset   (i_w_reset),
    .clear   (start || tick),
    .enable  (is_ticking(state)),
    .rate_div(i_w_rate_div),
    .due     (due)
  );

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state      <= S_IDLE;
      remaining  <= '0;
      skip       <= 1'b0;
      tick_count <= '0;
    end else begin
      if (tick) begin
        tick_count <= tick_count + 1'b1;
        skip       <= 1'b0;
      end
      if (i_w_halt) begin
        state     <= S_IDLE;
        remaining <= '0;
        skip      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_BREAK: begin
            // leaving a breakpoint arms skip so the stopped PC can be stepped past
            if (i_w_run) begin
              state <= S_RUN;
              skip  <= (state == S_BREAK);
            end else if (i_w_step) begin
              state     <= S_STEP;
              remaining <= burst_len;
              skip      <= (state == S_BREAK);
            end
          end
          S_STEP: begin
            if (i_w_run) begin
              state <= S_RUN;
            end else if (bp_block) begin
              state <= S_BREAK;
            end else if (tick) begin
              remaining <= remaining - 1'b1;
              if (remaining == count_one) state <= S_IDLE;
            end
          end
          S_RUN: begin
            if (bp_block) state <= S_BREAK;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_w_cpu_tick   = tick;
  assign o_w_state      = state;
  assign o_w_bp_hit     = (state == S_BREAK);
  assign o_w_tick_count = tick_count;

endmodule
